alu_control_mc: RTL and testbench

- Registered, handshaked successor to the combinational ALU-control decoder.
- Decodes ALUOp plus function code into an ALU select, one cycle after acceptance.
- Adds multi-cycle sequencing for new MULT/DIV function codes and flags illegal function codes.
- Sits between the main decoder/ID stage and the ALU in the multi-cycle datapath.

---
 rtl/alu_control_mc_if.sv | 26 ++
 rtl/alu_control_mc.sv | 138 +++++++++++++
 tb/tb_alu_control_mc.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_mc_if.sv
// Handshake bundle between the ID-stage decoder (master) and the registered ALU-control block (slave).
interface alu_control_mc_if #(
    parameter int FW = 6,
    parameter int GW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    aluop;
    logic [FW-1:0] funct;
    logic          flush;
    logic          out_valid;
    logic [GW-1:0] gout;
    logic [1:0]    mc_op;
    logic          busy;
    logic          illegal;

    modport master (
        output in_valid, aluop, funct, flush,
        input  in_ready, out_valid, gout, mc_op, busy, illegal
    );

    modport slave (
        input  in_valid, aluop, funct, flush,
        output in_ready, out_valid, gout, mc_op, busy, illegal
    );
endinterface

// File: rtl/alu_control_mc.sv
// Registered ALU-control decoder: one-cycle decode for single-cycle ops,
// busy-sequenced MULT/DIV with a down-counter, plus illegal R-type flagging.
module alu_control_mc #(
    parameter int FW      = 6,
    parameter int GW      = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input logic              clk,
    input logic              rst_n,
    alu_control_mc_if.slave  bus
);
    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(LAT_MAX);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    typedef enum logic {IDLE, MC} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [GW-1:0] r_gout, w_gout_nxt;
    logic [1:0]    r_mc_op, w_mc_op_nxt;
    logic          r_illegal, w_illegal_nxt;
    logic          r_sc_valid, w_sc_valid_nxt;

    logic          w_busy;
    logic          w_accept;
    logic          w_hi_zero;
    logic [2:0]    w_dec_sel;
    logic [1:0]    w_dec_mc;
    logic          w_dec_ill;

    assign w_busy    = (r_state == MC);
    assign w_accept  = bus.in_valid & ~w_busy;
    assign w_hi_zero = ((bus.funct >> 6) == '0);

    always_comb begin
        w_dec_sel = 3'b010;
        w_dec_mc  = 2'b00;
        w_dec_ill = 1'b0;
        case (bus.aluop)
            2'b00: w_dec_sel = 3'b010;
            2'b01: w_dec_sel = 3'b110;
            2'b11: w_dec_sel = 3'b011;
            default: begin
                if (!w_hi_zero) begin
                    w_dec_ill = 1'b1;
                end else begin
                    case (bus.funct[5:0])
                        6'b100000: w_dec_sel = 3'b010;
                        6'b100010: w_dec_sel = 3'b110;
                        6'b100100: w_dec_sel = 3'b000;
                        6'b100101: w_dec_sel = 3'b001;
                        6'b101010: w_dec_sel = 3'b111;
                        6'b100111: w_dec_sel = 3'b100;
                        6'b010101: w_dec_sel = 3'b010;
                        6'b011000: begin
                            w_dec_sel = 3'b101;
                            w_dec_mc  = 2'b01;
                        end
                        6'b011010: begin
                            w_dec_sel = 3'b101;
                            w_dec_mc  = 2'b10;
                        end
                        default:   w_dec_ill = 1'b1;
                    endcase
                end
            end
        endcase
    end

    // Flush wins over everything; the MC counter only loads from IDLE so it never wraps.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_gout_nxt     = r_gout;
        w_mc_op_nxt    = r_mc_op;
        w_illegal_nxt  = r_illegal;
        w_sc_valid_nxt = 1'b0;
        if (bus.flush) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_gout_nxt    = GW'(w_dec_sel);
                        w_mc_op_nxt   = w_dec_mc;
                        w_illegal_nxt = w_dec_ill;
                        if (w_dec_mc == 2'b01) begin
                            w_state_nxt = MC;
                            w_cnt_nxt   = MUL_LOAD;
                        end else if (w_dec_mc == 2'b10) begin
                            w_state_nxt = MC;
                            w_cnt_nxt   = DIV_LOAD;
                        end else begin
                            w_sc_valid_nxt = 1'b1;
                        end
                    end
                end
                MC: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_gout     <= GW'(3'b010);
            r_mc_op    <= 2'b00;
            r_illegal  <= 1'b0;
            r_sc_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gout     <= w_gout_nxt;
            r_mc_op    <= w_mc_op_nxt;
            r_illegal  <= w_illegal_nxt;
            r_sc_valid <= w_sc_valid_nxt;
        end
    end

    assign bus.in_ready  = ~w_busy;
    assign bus.busy      = w_busy;
    assign bus.out_valid = r_sc_valid | (w_busy & (r_cnt == '0));
    assign bus.gout      = r_gout;
    assign bus.mc_op     = r_mc_op;
    assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu_control_mc.sv
// Self-checking bench for alu_control_mc: directed scenarios plus randomized traffic
// against a cycle-count reference model.
module tb_alu_control_mc;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;
    localparam logic [8:0] RESET_VEC = 9'b0_0_1_00_0_010;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    int         mRemain;
    logic       mScPulse;
    logic [2:0] mGout;
    logic [1:0] mMc;
    logic       mIll;

    logic [5:0] fpool [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                              6'b100111, 6'b010101, 6'b011000, 6'b011010};

    always #5 clk = ~clk;

    alu_control_mc_if #(.FW(6), .GW(3)) bus ();
    alu_control_mc_if #(.FW(8), .GW(3)) bus8 ();

    alu_control_mc #(.FW(6), .GW(3), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    alu_control_mc #(.FW(8), .GW(3), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );

    // Packed view: {out_valid, busy, in_ready, mc_op, illegal, gout}
    function automatic logic [8:0] act();
        return {bus.out_valid, bus.busy, bus.in_ready, bus.mc_op, bus.illegal, bus.gout};
    endfunction

    function automatic logic [8:0] act8();
        return {bus8.out_valid, bus8.busy, bus8.in_ready, bus8.mc_op, bus8.illegal, bus8.gout};
    endfunction

    // Returns {mc_op, illegal, gout} straight from the decode table.
    function automatic logic [5:0] refDecode(input logic [1:0] op, input logic [7:0] f);
        if (op == 2'b00) return 6'b00_0_010;
        if (op == 2'b01) return 6'b00_0_110;
        if (op == 2'b11) return 6'b00_0_011;
        if (f[7:6] != 2'b00) return 6'b00_1_010;
        case (f[5:0])
            6'b100000: return 6'b00_0_010;
            6'b100010: return 6'b00_0_110;
            6'b100100: return 6'b00_0_000;
            6'b100101: return 6'b00_0_001;
            6'b101010: return 6'b00_0_111;
            6'b100111: return 6'b00_0_100;
            6'b010101: return 6'b00_0_010;
            6'b011000: return 6'b01_0_101;
            6'b011010: return 6'b10_0_101;
            default:   return 6'b00_1_010;
        endcase
    endfunction

    function automatic logic [8:0] expVec();
        return {(mRemain == 1) || mScPulse, mRemain > 0, mRemain == 0, mMc, mIll, mGout};
    endfunction

    task automatic modelReset();
        mRemain  = 0;
        mScPulse = 1'b0;
        mGout    = 3'b010;
        mMc      = 2'b00;
        mIll     = 1'b0;
    endtask

    // mRemain counts the busy cycles still to come, including the current one.
    task automatic modelEdge();
        logic [5:0] d;
        if (!rst_n) begin
            modelReset();
        end else if (bus.flush) begin
            mRemain  = 0;
            mScPulse = 1'b0;
        end else if (mRemain > 0) begin
            mRemain--;
            mScPulse = 1'b0;
        end else if (bus.in_valid) begin
            d     = refDecode(bus.aluop, {2'b00, bus.funct});
            mGout = d[2:0];
            mIll  = d[3];
            mMc   = d[5:4];
            if (mMc == 2'b01) begin
                mRemain  = MUL_LAT;
                mScPulse = 1'b0;
            end else if (mMc == 2'b10) begin
                mRemain  = DIV_LAT;
                mScPulse = 1'b0;
            end else begin
                mScPulse = 1'b1;
            end
        end else begin
            mScPulse = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic fl);
        bus.in_valid = v;
        bus.aluop    = op;
        bus.funct    = f;
        bus.flush    = fl;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'b00, 6'd0, 1'b0);
        bus8.in_valid = 1'b0;
        bus8.aluop    = 2'b00;
        bus8.funct    = 8'd0;
        bus8.flush    = 1'b0;
        rst_n = 1'b0;
        modelReset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        if (act() !== RESET_VEC) begin
            $display("[TB] FAIL reset_state got=%b want=%b", act(), RESET_VEC);
            failures++;
        end
        checks++;
        if (act8() !== RESET_VEC) begin
            $display("[TB] FAIL reset_state_fw8 got=%b want=%b", act8(), RESET_VEC);
            failures++;
        end
        checks++;
    endtask

    task automatic test_sub();
        drive(1'b1, 2'b10, 6'b100010, 1'b0);
        tick();
        if (act() !== 9'b1_0_1_00_0_110) begin
            $display("[TB] FAIL sub_decode got=%b want=%b", act(), 9'b1_0_1_00_0_110);
            failures++;
        end
        checks++;
        drive(1'b0, 2'b00, 6'd0, 1'b0);
        tick();
        if (act() !== 9'b0_0_1_00_0_110) begin
            $display("[TB] FAIL sub_hold got=%b want=%b", act(), 9'b0_0_1_00_0_110);
            failures++;
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops   [3] = '{2'b00, 2'b01, 2'b11};
        logic [2:0] gouts [3] = '{3'b010, 3'b110, 3'b011};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], 6'($urandom), 1'b0);
            tick();
            if (act() !== {3'b101, 2'b00, 1'b0, gouts[i]}) begin
                $display("[TB] FAIL b2b_%0d got=%b want=%b", i, act(), {3'b101, 2'b00, 1'b0, gouts[i]});
                failures++;
            end
            checks++;
        end
        drive(1'b0, 2'b00, 6'd0, 1'b0);
        tick();
        if (act() !== 9'b0_0_1_00_0_011) begin
            $display("[TB] FAIL b2b_idle got=%b want=%b", act(), 9'b0_0_1_00_0_011);
            failures++;
        end
        checks++;
    endtask

    task automatic test_mult();
        logic [8:0] want;
        drive(1'b1, 2'b10, 6'b011000, 1'b0);
        tick();
        drive(1'b1, 2'b00, 6'($urandom), 1'b0);
        for (int k = 1; k <= MUL_LAT; k++) begin
            want = {(k == MUL_LAT), 2'b10, 2'b01, 1'b0, 3'b101};
            if (act() !== want) begin
                $display("[TB] FAIL mult_busy_%0d got=%b want=%b", k, act(), want);
                failures++;
            end
            checks++;
            tick();
        end
        if (act() !== 9'b0_0_1_01_0_101) begin
            $display("[TB] FAIL mult_release got=%b want=%b", act(), 9'b0_0_1_01_0_101);
            failures++;
        end
        checks++;
        tick();
        if (act() !== 9'b1_0_1_00_0_010) begin
            $display("[TB] FAIL mult_held_accept got=%b want=%b", act(), 9'b1_0_1_00_0_010);
            failures++;
        end
        checks++;
        drive(1'b0, 2'b00, 6'd0, 1'b0);
        tick();
    endtask

    task automatic test_div_flush();
        drive(1'b1, 2'b10, 6'b011010, 1'b0);
        tick();
        drive(1'b0, 2'b00, 6'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            if (act() !== 9'b0_1_0_10_0_101) begin
                $display("[TB] FAIL div_busy_%0d got=%b want=%b", k, act(), 9'b0_1_0_10_0_101);
                failures++;
            end
            checks++;
            if (k < 3) tick();
        end
        drive(1'b0, 2'b00, 6'd0, 1'b1);
        tick();
        drive(1'b0, 2'b00, 6'd0, 1'b0);
        for (int k = 0; k < DIV_LAT; k++) begin
            if (act() !== 9'b0_0_1_10_0_101) begin
                $display("[TB] FAIL div_flushed_%0d got=%b want=%b", k, act(), 9'b0_0_1_10_0_101);
                failures++;
            end
            checks++;
            tick();
        end
        drive(1'b1, 2'b10, 6'b100000, 1'b0);
        tick();
        if (act() !== 9'b1_0_1_00_0_010) begin
            $display("[TB] FAIL add_after_flush got=%b want=%b", act(), 9'b1_0_1_00_0_010);
            failures++;
        end
        checks++;
        drive(1'b1, 2'b01, 6'd0, 1'b1);
        tick();
        if (act() !== 9'b0_0_1_00_0_010) begin
            $display("[TB] FAIL flush_discards_accept got=%b want=%b", act(), 9'b0_0_1_00_0_010);
            failures++;
        end
        checks++;
        drive(1'b0, 2'b00, 6'd0, 1'b0);
        tick();
    endtask

    task automatic test_illegal();
        drive(1'b1, 2'b10, 6'b111111, 1'b0);
        bus8.in_valid = 1'b1;
        bus8.aluop    = 2'b10;
        bus8.funct    = 8'h60;
        tick();
        if (act() !== 9'b1_0_1_00_1_010) begin
            $display("[TB] FAIL illegal_fw6 got=%b want=%b", act(), 9'b1_0_1_00_1_010);
            failures++;
        end
        checks++;
        if (act8() !== 9'b1_0_1_00_1_010) begin
            $display("[TB] FAIL illegal_fw8_upper got=%b want=%b", act8(), 9'b1_0_1_00_1_010);
            failures++;
        end
        checks++;
        drive(1'b1, 2'b00, 6'b111111, 1'b0);
        bus8.funct = 8'h20;
        tick();
        if (act() !== 9'b1_0_1_00_0_010) begin
            $display("[TB] FAIL legal_non_rtype got=%b want=%b", act(), 9'b1_0_1_00_0_010);
            failures++;
        end
        checks++;
        if (act8() !== 9'b1_0_1_00_0_010) begin
            $display("[TB] FAIL legal_fw8_add got=%b want=%b", act8(), 9'b1_0_1_00_0_010);
            failures++;
        end
        checks++;
        drive(1'b0, 2'b00, 6'd0, 1'b0);
        bus8.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_mult();
        drive(1'b1, 2'b10, 6'b011000, 1'b0);
        tick();
        drive(1'b0, 2'b00, 6'd0, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        if (act() !== RESET_VEC) begin
            $display("[TB] FAIL reset_mid_mult got=%b want=%b", act(), RESET_VEC);
            failures++;
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < MUL_LAT + 2; k++) begin
            tick();
            if (act() !== RESET_VEC) begin
                $display("[TB] FAIL no_pulse_after_reset_%0d got=%b want=%b", k, act(), RESET_VEC);
                failures++;
            end
            checks++;
        end
    endtask

    task automatic test_random();
        logic [5:0] f;
        for (int n = 0; n < 400; n++) begin
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fpool[$urandom_range(0, 8)];
            drive($urandom_range(0, 9) < 7, 2'($urandom), f, $urandom_range(0, 19) == 0);
            tick();
            if (act() !== expVec()) begin
                $display("[TB] FAIL random_cycle_%0d got=%b want=%b", n, act(), expVec());
                failures++;
            end
            checks++;
        end
        drive(1'b0, 2'b00, 6'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sub();
        test_back_to_back();
        test_mult();
        test_div_flush();
        test_illegal();
        test_reset_mid_mult();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
